// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer around the ID/EX register: load-use stalls, multi-cycle
// EX holds, branch flushes and a saturating stall-cycle counter.
module pipeline_hazard_ctrl #(
    parameter int unsigned MUL_LAT = 4,
    parameter int unsigned CNT_W   = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             IDEX_MemRead_i,
    input  logic [4:0]       IDEX_Rd_i,
    input  logic [4:0]       IFID_Rs1_i,
    input  logic [4:0]       IFID_Rs2_i,
    input  logic             IFID_UseRs2_i,
    input  logic             IDEX_Mul_i,
    input  logic             Branch_taken_i,
    output logic             PC_write_o,
    output logic             IFID_write_o,
    output logic             IFID_flush_o,
    output logic             IDEX_bubble_o,
    output logic             IDEX_hold_o,
    output logic             EXMEM_bubble_o,
    output logic             Mul_done_o,
    output logic [CNT_W-1:0] stall_cnt_o
);

    localparam int unsigned MCNT_W = (MUL_LAT > 2) ? $clog2(MUL_LAT) : 1;
    localparam logic [MCNT_W-1:0] MCNT_INIT = MCNT_W'(MUL_LAT - 2);

    typedef enum logic [0:0] {StRun, StMulWait} state_e;

    state_e            state_q, state_d;
    logic [MCNT_W-1:0] mcnt_q, mcnt_d;
    logic              live_q;
    logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
    logic              load_use;

    assign load_use = IDEX_MemRead_i && (IDEX_Rd_i != 5'd0) &&
                      ((IDEX_Rd_i == IFID_Rs1_i) ||
                       (IFID_UseRs2_i && (IDEX_Rd_i == IFID_Rs2_i)));

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q     <= StRun;
            mcnt_q      <= '0;
            live_q      <= 1'b0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            mcnt_q      <= mcnt_d;
            live_q      <= 1'b1;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    // Transitions only once live; the cycle after reset release is still inert.
    always_comb begin
        state_d = state_q;
        mcnt_d  = mcnt_q;
        if (live_q) begin
            unique case (state_q)
                StRun: begin
                    if (IDEX_Mul_i) begin
                        state_d = StMulWait;
                        mcnt_d  = MCNT_INIT;
                    end
                end
                StMulWait: begin
                    if (mcnt_q == '0) begin
                        state_d = StRun;
                    end else begin
                        mcnt_d = mcnt_q - MCNT_W'(1);
                    end
                end
                default: state_d = StRun;
            endcase
        end
    end

    // Priority inside RUN: MUL > load-use > branch flush.
    always_comb begin
        PC_write_o     = 1'b1;
        IFID_write_o   = 1'b1;
        IFID_flush_o   = 1'b0;
        IDEX_bubble_o  = 1'b0;
        IDEX_hold_o    = 1'b0;
        EXMEM_bubble_o = 1'b0;
        Mul_done_o     = 1'b0;
        if (!live_q) begin
            PC_write_o    = 1'b0;
            IFID_write_o  = 1'b0;
            IDEX_bubble_o = 1'b1;
        end else begin
            unique case (state_q)
                StRun: begin
                    if (IDEX_Mul_i) begin
                        PC_write_o     = 1'b0;
                        IFID_write_o   = 1'b0;
                        IDEX_hold_o    = 1'b1;
                        EXMEM_bubble_o = 1'b1;
                    end else if (load_use) begin
                        PC_write_o    = 1'b0;
                        IFID_write_o  = 1'b0;
                        IDEX_bubble_o = 1'b1;
                    end else begin
                        IFID_flush_o = Branch_taken_i;
                    end
                end
                StMulWait: begin
                    PC_write_o   = 1'b0;
                    IFID_write_o = 1'b0;
                    if (mcnt_q == '0) begin
                        Mul_done_o = 1'b1;
                    end else begin
                        IDEX_hold_o    = 1'b1;
                        EXMEM_bubble_o = 1'b1;
                    end
                end
                default: begin
                    PC_write_o   = 1'b0;
                    IFID_write_o = 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (live_q && !PC_write_o && (stall_cnt_q != {CNT_W{1'b1}})) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
    end

    assign stall_cnt_o = stall_cnt_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Randomized bench for pipeline_hazard_ctrl against a cycle-level reference model;
// a second CNT_W=4 instance exercises counter saturation.
module tb_pipeline_hazard_ctrl;

    localparam int unsigned MUL_LAT = 4;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b0;
    logic        mem_read, use_rs2, mul, br;
    logic [4:0]  rd, rs1, rs2;

    logic        pc_w, ifid_w, ifid_fl, idex_bub, idex_hold, exmem_bub, mul_done;
    logic [31:0] cnt;
    logic        s_pc_w, s_ifid_w, s_ifid_fl, s_idex_bub, s_idex_hold, s_exmem_bub, s_mul_done;
    logic [3:0]  s_cnt;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    // Reference model state
    bit      live_m   = 1'b0;
    int      mul_left = 0;
    longint  cnt_m    = 0;
    int      cnt4_m   = 0;

    always #5 clk_i = ~clk_i;

    pipeline_hazard_ctrl #(.MUL_LAT(MUL_LAT), .CNT_W(32)) u_dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .IDEX_MemRead_i(mem_read), .IDEX_Rd_i(rd), .IFID_Rs1_i(rs1), .IFID_Rs2_i(rs2),
        .IFID_UseRs2_i(use_rs2), .IDEX_Mul_i(mul), .Branch_taken_i(br),
        .PC_write_o(pc_w), .IFID_write_o(ifid_w), .IFID_flush_o(ifid_fl),
        .IDEX_bubble_o(idex_bub), .IDEX_hold_o(idex_hold), .EXMEM_bubble_o(exmem_bub),
        .Mul_done_o(mul_done), .stall_cnt_o(cnt)
    );

    pipeline_hazard_ctrl #(.MUL_LAT(MUL_LAT), .CNT_W(4)) u_dut_sat (
        .clk_i(clk_i), .rst_i(rst_i),
        .IDEX_MemRead_i(mem_read), .IDEX_Rd_i(rd), .IFID_Rs1_i(rs1), .IFID_Rs2_i(rs2),
        .IFID_UseRs2_i(use_rs2), .IDEX_Mul_i(mul), .Branch_taken_i(br),
        .PC_write_o(s_pc_w), .IFID_write_o(s_ifid_w), .IFID_flush_o(s_ifid_fl),
        .IDEX_bubble_o(s_idex_bub), .IDEX_hold_o(s_idex_hold), .EXMEM_bubble_o(s_exmem_bub),
        .Mul_done_o(s_mul_done), .stall_cnt_o(s_cnt)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
        end
    endtask

    task automatic set_in(input logic m_r, input logic [4:0] d, input logic [4:0] s1,
                          input logic [4:0] s2, input logic u2, input logic m,
                          input logic b);
        mem_read = m_r; rd = d; rs1 = s1; rs2 = s2; use_rs2 = u2; mul = m; br = b;
    endtask

    // One clock cycle: apply reset level, check outputs mid-cycle, advance the model.
    task automatic step(input logic r);
        logic e_pc, e_ifw, e_fl, e_bub, e_hold, e_exb, e_done, lu;
        rst_i = r;
        @(negedge clk_i);
        if (!rst_i) begin
            live_m = 1'b0; mul_left = 0; cnt_m = 0; cnt4_m = 0;
        end
        lu = mem_read && (rd != 0) && ((rd == rs1) || (use_rs2 && (rd == rs2)));
        e_pc = 1; e_ifw = 1; e_fl = 0; e_bub = 0; e_hold = 0; e_exb = 0; e_done = 0;
        if (!live_m) begin
            e_pc = 0; e_ifw = 0; e_bub = 1;
        end else if (mul_left > 0) begin
            e_pc = 0; e_ifw = 0;
            if (mul_left == 1) e_done = 1;
            else begin e_hold = 1; e_exb = 1; end
        end else if (mul) begin
            e_pc = 0; e_ifw = 0; e_hold = 1; e_exb = 1;
        end else if (lu) begin
            e_pc = 0; e_ifw = 0; e_bub = 1;
        end else begin
            e_fl = br;
        end
        check_eq("pc_write",     pc_w,      e_pc);
        check_eq("ifid_write",   ifid_w,    e_ifw);
        check_eq("ifid_flush",   ifid_fl,   e_fl);
        check_eq("idex_bubble",  idex_bub,  e_bub);
        check_eq("idex_hold",    idex_hold, e_hold);
        check_eq("exmem_bubble", exmem_bub, e_exb);
        check_eq("mul_done",     mul_done,  e_done);
        check_eq("stall_cnt",    cnt,       32'(cnt_m));
        check_eq("sat_stall_cnt", 32'(s_cnt), 32'(cnt4_m));
        check_eq("sat_pc_write", s_pc_w,    e_pc);
        if (rst_i) begin
            if (live_m) begin
                if (mul_left > 0) mul_left--;
                else if (mul) mul_left = MUL_LAT - 1;
                if (!e_pc) begin
                    cnt_m++;
                    if (cnt4_m < 15) cnt4_m++;
                end
            end
            live_m = 1'b1;
        end
        cyc++;
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        set_in(1, 5, 5, 5, 1, 1, 1);
        repeat (3) step(1'b0);

        // Release with no hazards; first cycle must still show reset values.
        set_in(0, 0, 0, 0, 0, 0, 0);
        repeat (10) step(1'b1);

        // Load-use on rs1, then the bubble has cleared MemRead.
        set_in(1, 5, 5, 0, 0, 0, 0); step(1'b1);
        set_in(0, 5, 5, 0, 0, 0, 0); step(1'b1);
        // rs2 match without UseRs2, and x0 match: no stall.
        set_in(1, 5, 1, 5, 0, 0, 0); step(1'b1);
        set_in(1, 0, 0, 0, 1, 0, 0); step(1'b1);
        // Load-use suppresses the branch flush; next cycle it flushes.
        set_in(1, 7, 2, 7, 1, 0, 1); step(1'b1);
        set_in(0, 7, 2, 7, 1, 0, 1); step(1'b1);

        // Multi-cycle op: entry plus three MUL_WAIT cycles.
        set_in(0, 0, 0, 0, 0, 1, 0); step(1'b1);
        set_in(1, 3, 3, 0, 0, 0, 1); repeat (3) step(1'b1);
        set_in(0, 0, 0, 0, 0, 0, 0); step(1'b1);

        // Reset in the 2nd MUL_WAIT cycle.
        set_in(0, 0, 0, 0, 0, 1, 0); step(1'b1);
        set_in(0, 0, 0, 0, 0, 0, 0); step(1'b1);
        step(1'b0);
        repeat (3) step(1'b1);

        // Randomized traffic with small register ranges to provoke hazards.
        for (int i = 0; i < 2000; i++) begin
            set_in(1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)),
                   5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                   1'($urandom_range(0, 1)), ($urandom_range(0, 7) == 0),
                   ($urandom_range(0, 2) == 0));
            step(($urandom_range(0, 63) == 0) ? 1'b0 : 1'b1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
